// File: rtl/fetch_decode_latch.sv
// -----------------------------------------------------------------------------
// fetch_decode_latch
//
// Owns the fetch PC register and the F/D pipeline register. Each instruction
// word returned by the synchronous imem (1-cycle read latency) is paired with
// the PC that addressed it, then presented to decode as a valid-qualified word.
// A decode stall parks the word that is already in flight from imem in a skid
// register, so no word is lost. An execute redirect squashes everything in
// flight for SQUASH_CYCLES cycles of bubbles.
//
// Parameters:
//   RESET_PC       PC loaded while reset is asserted.
//   SQUASH_CYCLES  fd_valid=0 cycles forced after a redirect (legal 1..3).
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   asynchronous, active-low
//   pc_next   [31:0] in   next PC from fetch stage (pc+1 or redirect target)
//   branched_jumped  in   execute redirect taken this cycle
//   stall            in   decode cannot accept fd_* this cycle
//   q_imem    [31:0] in   imem read data for the address presented last cycle
//   pc_fetch  [31:0] out  current fetch PC, feeds fetch-stage pc_in
//   fd_pc     [31:0] out  PC of the instruction held in F/D
//   fd_insn   [31:0] out  instruction held in F/D
//   fd_valid         out  F/D holds a real instruction (0 = bubble)
//   squashing        out  high while squashing after a redirect
//
// Optional feature, macro FD_PERF_COUNTERS_EN:
//   stall_count  [31:0] out  edges spent holding F/D for a stall (saturating)
//   squash_count [31:0] out  accepted redirects (saturating)
// -----------------------------------------------------------------------------
module fetch_decode_latch #(
   parameter logic [31:0] RESET_PC      = 32'd0,
   parameter int unsigned SQUASH_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pc_next,
   input  logic        branched_jumped,
   input  logic        stall,
   input  logic [31:0] q_imem,
   output logic [31:0] pc_fetch,
   output logic [31:0] fd_pc,
   output logic [31:0] fd_insn,
   output logic        fd_valid,
   output logic        squashing
`ifdef FD_PERF_COUNTERS_EN
   ,
   output logic [31:0] stall_count,
   output logic [31:0] squash_count
`endif
);

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_STALL  = 2'd1;
   localparam logic [1:0] ST_SQUASH = 2'd2;

   // Count loaded on a redirect; zero means the bubbles are covered by the
   // pipeline drain alone and no SQUASH state is needed.
   localparam logic [1:0] SQ_INIT = 2'(SQUASH_CYCLES - 1);

   logic [1:0]  r_state;
   logic [1:0]  r_cnt;

   logic [31:0] r_pc_p0;

   logic [31:0] r_pend_pc_p1;
   logic        r_pend_vld_p1;
   logic [31:0] r_hold_insn_p1;
   logic        r_hold_vld_p1;

   logic [31:0] r_fd_pc_p2;
   logic [31:0] r_fd_insn_p2;
   logic        r_fd_vld_p2;

   logic        w_take_stall;
   logic        w_capture;

   // A stall is honoured only outside SQUASH and only when no redirect wins.
   assign w_take_stall = !branched_jumped && (r_state != ST_SQUASH) && stall;
   // The in-flight imem word is parked only on the edge that enters STALL;
   // while already stalled, q_imem carries a refetch of the frozen pc_fetch.
   assign w_capture    = w_take_stall && (r_state == ST_RUN);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_RUN;
         r_cnt         <= 2'd0;
         r_pc_p0       <= RESET_PC;
         r_pend_pc_p1  <= 32'd0;
         r_pend_vld_p1 <= 1'b0;
         r_hold_vld_p1 <= 1'b0;
         r_fd_pc_p2    <= 32'd0;
         r_fd_insn_p2  <= 32'd0;
         r_fd_vld_p2   <= 1'b0;
      end else if (branched_jumped) begin
         // Redirect: everything fetched on the old path is discarded.
         r_pc_p0       <= pc_next;
         r_pend_pc_p1  <= r_pc_p0;
         r_pend_vld_p1 <= 1'b0;
         r_hold_vld_p1 <= 1'b0;
         r_fd_vld_p2   <= 1'b0;
         r_cnt         <= SQ_INIT;
         r_state       <= (SQ_INIT != 2'd0) ? ST_SQUASH : ST_RUN;
      end else if (r_state == ST_SQUASH) begin
         // Fetch runs down the target path while F/D is forced to bubbles.
         r_pc_p0       <= pc_next;
         r_pend_pc_p1  <= r_pc_p0;
         r_pend_vld_p1 <= 1'b1;
         r_fd_vld_p2   <= 1'b0;
         r_cnt         <= r_cnt - 2'd1;
         if (r_cnt <= 2'd1) begin
            r_state <= ST_RUN;
         end
      end else if (w_take_stall) begin
         // Freeze pc_fetch and F/D; the word arriving now moves to the skid.
         r_state <= ST_STALL;
         if (w_capture) begin
            r_hold_vld_p1 <= r_pend_vld_p1;
            r_pend_vld_p1 <= 1'b0;
         end
      end else begin
         // Normal advance (also the STALL release edge).
         r_state       <= ST_RUN;
         r_pc_p0       <= pc_next;
         // ---- stage p0 -> p1: address presented last edge pairs with q_imem
         r_pend_pc_p1  <= r_pc_p0;
         r_pend_vld_p1 <= 1'b1;
         r_hold_vld_p1 <= 1'b0;
         // ---- stage p1 -> p2: skid word has priority over the live imem word
         r_fd_pc_p2    <= r_pend_pc_p1;
         r_fd_insn_p2  <= r_hold_vld_p1 ? r_hold_insn_p1 : q_imem;
         r_fd_vld_p2   <= r_pend_vld_p1 | r_hold_vld_p1;
      end
   end

   // Skid data carries no reset: it is only read when r_hold_vld_p1 is set.
   always_ff @(posedge clock) begin
      if (w_capture) begin
         r_hold_insn_p1 <= q_imem;
      end
   end

   assign pc_fetch  = r_pc_p0;
   assign fd_pc     = r_fd_pc_p2;
   assign fd_insn   = r_fd_insn_p2;
   assign fd_valid  = r_fd_vld_p2;
   assign squashing = (r_state == ST_SQUASH);

`ifdef FD_PERF_COUNTERS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [31:0] r_stall_cnt;
   logic [31:0] r_squash_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_stall_cnt  <= 32'd0;
         r_squash_cnt <= 32'd0;
      end else begin
         if (w_take_stall) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
         end
         if (branched_jumped) begin
            r_squash_cnt <= sat_inc(r_squash_cnt);
         end
      end
   end

   assign stall_count  = r_stall_cnt;
   assign squash_count = r_squash_cnt;
`endif

endmodule

// File: tb/tb_fetch_decode_latch.sv
// -----------------------------------------------------------------------------
// tb_fetch_decode_latch
//
// Drives fetch_decode_latch with a fetch stage (pc_next = pc_fetch + 1 unless
// redirecting) and a 1-cycle-latency imem whose word for address a is
// a ^ 32'hA5A5_0000. Expected outputs come from a transaction-level model:
// an in-flight FIFO of fetched addresses, a fetch PC, and a bubble counter.
// Optional counter ports are exercised when FD_PERF_COUNTERS_EN is defined.
// -----------------------------------------------------------------------------
module tb_fetch_decode_latch;

   localparam logic [31:0] RESET_PC = 32'd0;
   localparam int          SQ_CYC   = 2;
   localparam logic [31:0] KEY      = 32'hA5A5_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        branched_jumped = 1'b0;
   logic [31:0] br_tgt = 32'd0;
   logic [31:0] pc_next;
   logic [31:0] q_imem = 32'd0;
   logic [31:0] pc_fetch;
   logic [31:0] fd_pc;
   logic [31:0] fd_insn;
   logic        fd_valid;
   logic        squashing;
`ifdef FD_PERF_COUNTERS_EN
   logic [31:0] stall_count;
   logic [31:0] squash_count;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [31:0] m_pc;
   logic [31:0] m_q[$];
   logic [31:0] m_fd_pc;
   logic        m_fd_vld;
   int          m_sq;
   int          m_stall_cnt;
   int          m_sq_cnt;

   fetch_decode_latch #(
      .RESET_PC      (RESET_PC),
      .SQUASH_CYCLES (SQ_CYC)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .pc_next         (pc_next),
      .branched_jumped (branched_jumped),
      .stall           (stall),
      .q_imem          (q_imem),
      .pc_fetch        (pc_fetch),
      .fd_pc           (fd_pc),
      .fd_insn         (fd_insn),
      .fd_valid        (fd_valid),
      .squashing       (squashing)
`ifdef FD_PERF_COUNTERS_EN
      ,
      .stall_count     (stall_count),
      .squash_count    (squash_count)
`endif
   );

   always #5 clock = ~clock;

   // Fetch stage and imem environment
   assign pc_next = branched_jumped ? br_tgt : pc_fetch + 32'd1;
   always @(posedge clock) q_imem <= pc_fetch ^ KEY;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = RESET_PC;
      m_q.delete();
      m_fd_pc = 32'd0;
      m_fd_vld = 1'b0;
      m_sq = 0;
      m_stall_cnt = 0;
      m_sq_cnt = 0;
   endtask

   // One clock edge of the reference model, given the inputs seen at it.
   task automatic model_edge(input logic s, input logic b, input logic [31:0] t);
      if (b) begin
         m_sq_cnt++;
         m_pc = t;
         m_q.delete();
         m_fd_vld = 1'b0;
         m_sq = SQ_CYC - 1;
      end else if (m_sq > 0) begin
         m_fd_vld = 1'b0;
         if (m_q.size() > 0) void'(m_q.pop_front());
         m_q.push_back(m_pc);
         m_pc = m_pc + 32'd1;
         m_sq--;
      end else if (s) begin
         m_stall_cnt++;
      end else begin
         if (m_q.size() > 0) begin
            m_fd_pc = m_q.pop_front();
            m_fd_vld = 1'b1;
         end else begin
            m_fd_vld = 1'b0;
         end
         m_q.push_back(m_pc);
         m_pc = m_pc + 32'd1;
      end
   endtask

   task automatic check_all();
      chk("pc_fetch", pc_fetch, m_pc);
      chk("fd_valid", {31'd0, fd_valid}, {31'd0, m_fd_vld});
      chk("squashing", {31'd0, squashing}, {31'd0, (m_sq > 0)});
      if (m_fd_vld) begin
         chk("fd_pc", fd_pc, m_fd_pc);
         chk("fd_insn", fd_insn, m_fd_pc ^ KEY);
      end
   endtask

   // Called at a negedge: apply inputs, take one posedge, check at the next negedge.
   task automatic step(input logic s, input logic b, input logic [31:0] t);
      stall = s;
      branched_jumped = b;
      br_tgt = t;
      @(posedge clock);
      model_edge(s, b, t);
      @(negedge clock);
      check_all();
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_pc_fetch"}, pc_fetch, RESET_PC);
      chk({tag, "_fd_valid"}, {31'd0, fd_valid}, 32'd0);
      chk({tag, "_squashing"}, {31'd0, squashing}, 32'd0);
      chk({tag, "_fd_pc"}, fd_pc, 32'd0);
      chk({tag, "_fd_insn"}, fd_insn, 32'd0);
   endtask

   initial begin
      logic s;
      logic b;
      model_reset();

      // Power-on reset
      #3 reset = 1'b0;
      repeat (2) @(negedge clock);
      check_reset_vals("por");
      reset = 1'b1;

      // Straight-line fetch: fd_pc follows two edges behind pc_fetch
      step(1'b0, 1'b0, 32'd0);
      chk("first_edge_bubble", {31'd0, fd_valid}, 32'd0);
      step(1'b0, 1'b0, 32'd0);
      chk("edge2_fd_pc", fd_pc, 32'd0);
      chk("edge2_fd_valid", {31'd0, fd_valid}, 32'd1);
      repeat (5) step(1'b0, 1'b0, 32'd0);
      chk("steady_fd_pc", fd_pc, 32'd5);

      // Three stall cycles with fd_pc=5
      repeat (3) begin
         step(1'b1, 1'b0, 32'd0);
         chk("stall_fd_pc", fd_pc, 32'd5);
         chk("stall_pc_fetch", pc_fetch, 32'd7);
      end
      step(1'b0, 1'b0, 32'd0);
      chk("release_fd_pc", fd_pc, 32'd6);
      chk("release_fd_insn", fd_insn, 32'd6 ^ KEY);
      step(1'b0, 1'b0, 32'd0);
      chk("after_release_fd_pc", fd_pc, 32'd7);
      step(1'b0, 1'b0, 32'd0);

      // Redirect to 0x40 while fd_pc=8
      step(1'b0, 1'b1, 32'h40);
      chk("redir_pc_fetch", pc_fetch, 32'h40);
      chk("redir_squashing", {31'd0, squashing}, 32'd1);
      step(1'b0, 1'b0, 32'd0);
      chk("redir_bubble2", {31'd0, fd_valid}, 32'd0);
      step(1'b0, 1'b0, 32'd0);
      chk("redir_target_fd_pc", fd_pc, 32'h40);
      chk("redir_target_valid", {31'd0, fd_valid}, 32'd1);

      // Redirect and stall together while stalled; stall ignored during squash
      repeat (2) step(1'b0, 1'b0, 32'd0);
      step(1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b1, 32'h100);
      chk("stall_redir_pc", pc_fetch, 32'h100);
      step(1'b1, 1'b0, 32'd0);
      chk("squash_ignores_stall", pc_fetch, 32'h101);
      step(1'b1, 1'b0, 32'd0);
      step(1'b0, 1'b0, 32'd0);
      chk("stall_redir_target", fd_pc, 32'h100);
      step(1'b0, 1'b0, 32'd0);

      // Redirect near the top of the address space: pc_next wraps in fetch
      step(1'b0, 1'b1, 32'hFFFF_FFFE);
      repeat (5) step(1'b0, 1'b0, 32'd0);

      // Asynchronous reset in the middle of SQUASH
      step(1'b0, 1'b1, 32'h200);
      #2 reset = 1'b0;
      #1 check_reset_vals("mid_squash");
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      repeat (3) step(1'b0, 1'b0, 32'd0);

      // Asynchronous reset in the middle of STALL: held word must vanish
      step(1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b0, 32'd0);
      #2 reset = 1'b0;
      #1 check_reset_vals("mid_stall");
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      repeat (3) step(1'b0, 1'b0, 32'd0);

      // Random stalls and redirects
      for (int i = 0; i < 400; i++) begin
         s = ($urandom_range(0, 3) == 0);
         b = ($urandom_range(0, 11) == 0);
         step(s, b, $urandom);
      end

`ifdef FD_PERF_COUNTERS_EN
      chk("stall_count", stall_count, m_stall_cnt);
      chk("squash_count", squash_count, m_sq_cnt);
      #2 reset = 1'b0;
      #1 model_reset();
      @(negedge clock);
      reset = 1'b1;
      repeat (2) step(1'b0, 1'b0, 32'd0);
      repeat (4) step(1'b1, 1'b0, 32'd0);
      step(1'b0, 1'b1, 32'h80);
      repeat (3) step(1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b1, 32'h90);
      repeat (3) step(1'b0, 1'b0, 32'd0);
      chk("plan_stall_count", stall_count, 32'd4);
      chk("plan_squash_count", squash_count, 32'd2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
